// File: rtl/cvsd_pkg.sv
// Shared types and constants for the CVSD decoder sequencer.
package cvsd_pkg;
  localparam int unsigned PCM_W     = 16;
  localparam logic        IDLE_BIT0 = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FLUSH = 2'd3
  } cvsd_ctrl_state_t;
endpackage

// File: rtl/cvsd_bit_fifo.sv
// 1-bit wide FIFO buffering CVSD bits ahead of the decoder sequencer.
module cvsd_bit_fifo #(
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic push_i,
  input  logic pop_i,
  input  logic din_i,
  output logic dout_o,
  output logic full_o,
  output logic empty_o
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  logic [FIFO_DEPTH-1:0] r_mem;
  logic [AW:0]           r_wr;
  logic [AW:0]           r_rd;
  logic [AW:0]           w_count;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign w_count = r_wr - r_rd;
  assign full_o  = w_count[AW];
  assign empty_o = (w_count == '0);
  assign dout_o  = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_mem <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
    end else begin
      if (push_i) begin
        r_mem[r_wr[AW-1:0]] <= din_i;
        r_wr                <= r_wr + 1'b1;
      end
      if (pop_i) begin
        r_rd <= r_rd + 1'b1;
      end
    end
  end
endmodule

// File: rtl/cvsd_dec_ctrl.sv
// CVSD decoder sequencer: bit FIFO, bit-period divider, idle-pattern
// insertion on underrun, and delayed capture of the decoder PCM output.
module cvsd_dec_ctrl
  import cvsd_pkg::*;
#(
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned DEC_LAT    = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic             bit_i,
  input  logic             bit_valid_i,
  output logic             bit_ready_o,
  output logic             dec_enable_o,
  output logic             dec_data_o,
  input  logic [PCM_W-1:0] dec_pcm_i,
  output logic [PCM_W-1:0] pcm_o,
  output logic             pcm_valid_o,
  output logic             underrun_o,
  output logic             busy_o
);
  localparam int unsigned FW = $clog2(DEC_LAT) + 1;

  cvsd_ctrl_state_t r_state;
  logic [DIV_W-1:0]   r_div_q;
  logic [DIV_W-1:0]   r_cnt;
  logic [FW-1:0]      r_flush_cnt;
  logic               r_toggle;
  logic               r_dec_en;
  logic               r_dec_data;
  logic [DEC_LAT-1:0] r_dly;
  logic [PCM_W-1:0]   r_pcm;
  logic               r_pcm_valid;
  logic               r_underrun;

  logic               w_full;
  logic               w_empty;
  logic               w_fifo_dout;
  logic               w_push;
  logic               w_pop;
  logic               w_tick;
  logic               w_en_next;
  logic               w_data_next;
  logic [DEC_LAT-1:0] w_dly_next;

  assign bit_ready_o  = !w_full && (r_state != DRAIN);
  assign w_push       = bit_valid_i && bit_ready_o;
  assign w_tick       = ((r_state == RUN) || (r_state == DRAIN)) && (r_cnt == '0);
  assign dec_enable_o = r_dec_en;
  assign dec_data_o   = r_dec_data;
  assign pcm_o        = r_pcm;
  assign pcm_valid_o  = r_pcm_valid;
  assign underrun_o   = r_underrun;
  assign busy_o       = (r_state != IDLE);

  cvsd_bit_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .din_i   (bit_i),
    .dout_o  (w_fifo_dout),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  // Idle bits are only inserted while running; an empty tick in DRAIN ends the stream.
  always_comb begin
    w_pop       = 1'b0;
    w_en_next   = 1'b0;
    w_data_next = r_dec_data;
    if (w_tick) begin
      if (!w_empty) begin
        w_pop       = 1'b1;
        w_en_next   = 1'b1;
        w_data_next = w_fifo_dout;
      end else if (r_state == RUN) begin
        w_en_next   = 1'b1;
        w_data_next = r_toggle;
      end
    end
  end

  // The delay line is fed with the enable about to be registered, so its tail
  // lines up with the capture edge giving pcm_valid_o exactly DEC_LAT after the enable.
  always_comb begin
    w_dly_next    = r_dly << 1;
    w_dly_next[0] = w_en_next;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state     <= IDLE;
      r_div_q     <= '0;
      r_cnt       <= '0;
      r_flush_cnt <= '0;
      r_toggle    <= IDLE_BIT0;
      r_dec_en    <= 1'b0;
      r_dec_data  <= 1'b0;
      r_dly       <= '0;
      r_pcm       <= '0;
      r_pcm_valid <= 1'b0;
      r_underrun  <= 1'b0;
    end else begin
      r_dec_en    <= w_en_next;
      r_dec_data  <= w_data_next;
      r_dly       <= w_dly_next;
      r_pcm_valid <= r_dly[DEC_LAT-1];
      if (r_dly[DEC_LAT-1]) begin
        r_pcm <= dec_pcm_i;
      end

      if (w_tick && !w_empty) begin
        r_toggle <= IDLE_BIT0;
      end

      if ((r_state == RUN) || (r_state == DRAIN)) begin
        r_cnt <= (r_cnt == '0) ? r_div_q : r_cnt - 1'b1;
      end

      case (r_state)
        IDLE: begin
          if (start_i && !stop_i) begin
            r_div_q    <= div_i;
            r_cnt      <= div_i;
            r_underrun <= 1'b0;
            r_state    <= RUN;
          end
        end
        RUN: begin
          if (w_tick && w_empty) begin
            r_toggle   <= ~r_toggle;
            r_underrun <= 1'b1;
          end
          if (stop_i) begin
            r_state <= DRAIN;
          end
        end
        DRAIN: begin
          if (w_tick && w_empty) begin
            r_flush_cnt <= FW'(DEC_LAT - 1);
            r_state     <= FLUSH;
          end
        end
        FLUSH: begin
          if (r_flush_cnt == '0) begin
            r_state <= IDLE;
          end else begin
            r_flush_cnt <= r_flush_cnt - 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cvsd_dec_ctrl.sv
// Directed bench for cvsd_dec_ctrl (DIV_W=16, FIFO_DEPTH=8, DEC_LAT=2).
module tb_cvsd_dec_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic [15:0] div = '0;
  logic        bit_in = 1'b0;
  logic        bit_valid = 1'b0;
  logic        bit_ready;
  logic        dec_en;
  logic        dec_data;
  logic [15:0] dec_pcm;
  logic [15:0] pcm;
  logic        pcm_valid;
  logic        underrun;
  logic        busy;
  logic [15:0] cyc = '0;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 16'd1;
  assign dec_pcm = 16'hA000 + cyc;

  cvsd_dec_ctrl #(
    .DIV_W      (16),
    .FIFO_DEPTH (8),
    .DEC_LAT    (2)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .stop_i       (stop),
    .div_i        (div),
    .bit_i        (bit_in),
    .bit_valid_i  (bit_valid),
    .bit_ready_o  (bit_ready),
    .dec_enable_o (dec_en),
    .dec_data_o   (dec_data),
    .dec_pcm_i    (dec_pcm),
    .pcm_o        (pcm),
    .pcm_valid_o  (pcm_valid),
    .underrun_o   (underrun),
    .busy_o       (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    bit_valid = 1'b0;
    bit_in = 1'b0;
    div = '0;
    step();
    step();
    rst = 1'b1;
    step();
  endtask

  initial begin
    logic [6:0]  t1_bits;
    logic [15:0] t2_bits;
    logic [2:0]  t4_bits;
    int          np;

    // ---- reset state ----
    do_reset();
    check("rst_ready", bit_ready, 1);
    check("rst_en", dec_en, 0);
    check("rst_data", dec_data, 0);
    check("rst_pcm", pcm, 0);
    check("rst_pcmv", pcm_valid, 0);
    check("rst_under", underrun, 0);
    check("rst_busy", busy, 0);

    // ---- test 1: prefill 1,0,1,1, div=3, then idle pattern 1,0,1 ----
    t1_bits = 7'b1011101; // index 0 first: 1,0,1,1,1,0,1
    for (int i = 0; i < 4; i++) begin
      bit_valid = 1'b1;
      bit_in = t1_bits[i];
      step();
    end
    bit_valid = 1'b0;
    div = 16'd3;
    start = 1'b1;
    step();
    start = 1'b0;
    check("t1_busy", busy, 1);
    for (int k = 0; k < 7; k++) begin
      for (int s = 1; s <= 4; s++) begin
        step();
        check("t1_en", dec_en, (s == 4) ? 1 : 0);
        check("t1_pcmv", pcm_valid, (s == 2 && k > 0) ? 1 : 0);
        if (s == 2 && k > 0) check("t1_pcm", pcm, 16'hA000 + cyc - 16'd1);
        if (s == 4) begin
          check("t1_data", dec_data, t1_bits[k]);
          check("t1_under", underrun, (k >= 4) ? 1 : 0);
        end
      end
    end

    // ---- test 2: div=0, 16-bit continuous stream ----
    do_reset();
    t2_bits = 16'b1000_0111_0100_1101;
    bit_valid = 1'b1;
    bit_in = t2_bits[0];
    step();
    bit_in = t2_bits[1];
    div = 16'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int c = 1; c <= 18; c++) begin
      if (c + 1 <= 15) begin
        bit_valid = 1'b1;
        bit_in = t2_bits[c + 1];
      end else begin
        bit_valid = 1'b0;
      end
      step();
      check("t2_en", dec_en, 1);
      if (c <= 16) check("t2_data", dec_data, t2_bits[c - 1]);
      check("t2_pcmv", pcm_valid, (c >= 3) ? 1 : 0);
      if (c >= 3) check("t2_pcm", pcm, 16'hA000 + cyc - 16'd1);
      if (c == 16) check("t2_under0", underrun, 0);
      if (c == 17) check("t2_under1", underrun, 1);
    end

    // ---- test 3: fill FIFO without start ----
    do_reset();
    bit_in = 1'b0;
    bit_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      step();
      check("t3_ready", bit_ready, (k < 8) ? 1 : 0);
      check("t3_en", dec_en, 0);
    end
    div = 16'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    check("t3_ready_s", bit_ready, 0);
    step();
    check("t3_ready_pop", bit_ready, 1);
    check("t3_en1", dec_en, 1);
    check("t3_data1", dec_data, 0);

    // ---- test 4: stop with 3 bits buffered, div=1 ----
    do_reset();
    t4_bits = 3'b110; // 0,1,1
    for (int i = 0; i < 3; i++) begin
      bit_valid = 1'b1;
      bit_in = t4_bits[i];
      step();
    end
    bit_valid = 1'b0;
    div = 16'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("t4_busy0", busy, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    np = 0;
    for (int c = 1; c <= 11; c++) begin
      if (c > 1) step();
      check("t4_en", dec_en, (c == 2 || c == 4 || c == 6) ? 1 : 0);
      if (c == 2 || c == 4 || c == 6) begin
        check("t4_data", dec_data, t4_bits[np]);
        np++;
      end
      check("t4_pcmv", pcm_valid, (c == 4 || c == 6 || c == 8) ? 1 : 0);
      check("t4_busy", busy, (c < 10) ? 1 : 0);
      check("t4_ready", bit_ready, (c <= 7) ? 0 : 1);
    end
    check("t4_under", underrun, 0);

    // ---- test 5: start+stop together; start clears sticky underrun ----
    div = 16'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("t5_under_set", underrun, 1);
    stop = 1'b1;
    step();
    stop = 1'b0;
    repeat (4) step();
    check("t5_idle", busy, 0);
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    check("t5_both_busy", busy, 0);
    check("t5_both_under", underrun, 1);
    step();
    check("t5_both_busy2", busy, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("t5_start_busy", busy, 1);
    check("t5_start_under", underrun, 0);

    // ---- test 6: reset mid-RUN with 5 bits buffered ----
    do_reset();
    bit_in = 1'b0;
    bit_valid = 1'b1;
    repeat (6) step();
    bit_valid = 1'b0;
    div = 16'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("t6_en_pre", dec_en, 1);
    check("t6_data_pre", dec_data, 0);
    rst = 1'b0;
    #1;
    check("t6_en", dec_en, 0);
    check("t6_data", dec_data, 0);
    check("t6_pcmv", pcm_valid, 0);
    check("t6_pcm", pcm, 0);
    check("t6_under", underrun, 0);
    check("t6_busy", busy, 0);
    check("t6_ready", bit_ready, 1);
    step();
    step();
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("t6_post_pcmv", pcm_valid, 0);
      check("t6_post_ready", bit_ready, 1);
    end
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    check("t6_idle_en", dec_en, 1);
    check("t6_idle_data", dec_data, 1);
    check("t6_idle_under", underrun, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/cvsd_dec_ctrl.md
Name: cvsd_dec_ctrl

Overview:
Sequencer for the CVSD decoder datapath (shift register, comparator, step-size mux, accumulator).
- Buffers incoming CVSD bits from an upstream valid/ready source in a small FIFO.
- Issues one single-cycle decoder enable per bit period from a programmable clock divider.
- Captures the decoder's 16-bit PCM output into a registered output with a valid strobe.
- On underrun, substitutes an idle 1/0 pattern so the decoder output settles instead of ramping.

Parameters:
DIV_W, 16, width of the bit-period divider.
FIFO_DEPTH, 8, input bit FIFO depth; power of two, minimum 2.
DEC_LAT, 2, clk cycles from a dec_enable_o pulse to a valid decoder output on dec_pcm_i; minimum 1.

Ports:
clk_i  input  1  system clock, all logic on the rising edge.
rst_i  input  1  reset, asynchronous, active-low.
start_i  input  1  pulse; begins decoding from IDLE.
stop_i  input  1  pulse; requests graceful stop (drain FIFO, flush pipeline).
div_i  input  DIV_W  bit period minus 1, in clk cycles; sampled on start.
bit_i  input  1  CVSD bit from upstream.
bit_valid_i  input  1  bit_i is valid.
bit_ready_o  output  1  FIFO accepts bit_i this cycle.
dec_enable_o  output  1  single-cycle enable to the decoder.
dec_data_o  output  1  bit presented to the decoder; qualified by dec_enable_o.
dec_pcm_i  input  16  decoder PCM output.
pcm_o  output  16  captured PCM sample.
pcm_valid_o  output  1  single-cycle strobe; pcm_o updated this cycle.
underrun_o  output  1  sticky; the FIFO was empty at a bit tick.
busy_o  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst_i low, asynchronous):
  - All outputs are 0, except bit_ready_o, which is 1 after reset.
  - FIFO empty, state IDLE, divider counter 0, idle-pattern toggle 1, enable delay line cleared.
  - Reset mid-operation aborts immediately; in-flight pcm strobes are lost.
- States: IDLE, RUN, DRAIN, FLUSH.
- IDLE:
  - FIFO accepts bits, so upstream can prefill.
  - start_i: latch div_i into div_q, load counter with div_q, clear underrun_o, go to RUN.
  - start_i and stop_i in the same cycle: stop wins; stay IDLE.
  - stop_i alone is ignored.
- RUN:
  - Counter decrements each cycle. At 0 it generates a tick and reloads div_q. div_q=0 gives a tick every cycle.
  - Tick with FIFO not empty: pop, and on the next cycle dec_enable_o=1 and dec_data_o=the popped bit.
  - Tick with FIFO empty:
    - dec_enable_o=1 next cycle; dec_data_o=toggle, starting at 1; toggle then inverts.
    - underrun_o is set.
    - The toggle resets to 1 when a real bit is next popped.
  - stop_i goes to DRAIN. start_i is ignored.
- DRAIN:
  - bit_ready_o=0.
  - Ticks continue and pop remaining bits; no idle-pattern insertion.
  - At the first tick with the FIFO empty, go to FLUSH with no enable issued.
- FLUSH: wait DEC_LAT cycles so the last pcm_valid_o emits, then go to IDLE.
- FIFO rules:
  - bit_ready_o = !full && state!=DRAIN.
  - Push when bit_valid_i && bit_ready_o.
  - Simultaneous push and pop leaves the count unchanged; order is preserved.
  - A full FIFO deasserts ready; no overwrite.
- PCM capture:
  - The dec_enable_o pulse is delayed through a DEC_LAT-deep shift line.
  - When the delayed pulse emerges: pcm_o <= dec_pcm_i and pcm_valid_o=1 for one cycle.
  - pcm_o holds between strobes.
- Latency: tick cycle T gives dec_enable_o at T+1 and pcm_valid_o at T+1+DEC_LAT.

Decomposition:
- Package cvsd_pkg:
  - State enum cvsd_ctrl_state_t (IDLE, RUN, DRAIN, FLUSH).
  - Constant PCM_W=16.
  - Idle-pattern start value constant IDLE_BIT0=1'b1.
- Sub-module cvsd_bit_fifo:
  - Parameter FIFO_DEPTH; 1-bit wide.
  - Ports: push, pop, din, dout, full, empty.
  - Same clk_i/rst_i convention.

Test Plan:
- Prefill 4 bits 1,0,1,1 in IDLE, div_i=3, start -> dec_enable_o pulses every 4 cycles carrying 1,0,1,1, then underrun idle bits 1,0,1... with underrun_o=1.
- div_i=0, continuous valid stream of 16 bits -> dec_enable_o high 16 consecutive cycles; pcm_valid_o follows each by DEC_LAT=2 with pcm_o = dec_pcm_i sampled at that cycle.
- Hold bit_valid_i=1 without start -> bit_ready_o drops after 8 pushes; no enables; start then resumes ready after the first pop.
- stop_i with 3 bits buffered -> 3 more enables, no idle bits, busy_o low exactly DEC_LAT cycles after the last pcm_valid_o; bit_ready_o=0 throughout DRAIN.
- start_i and stop_i together in IDLE -> stays IDLE, busy_o=0; second start clears a previous sticky underrun_o.
- rst_i low mid-RUN with FIFO holding 5 bits -> all outputs 0 immediately; after release FIFO empty, bit_ready_o=1, no pcm_valid_o from pre-reset enables.
